fp16_pack: RTL and testbench
============================

# fp16_pack

Output stage of the fp16 datapath and the inverse of the input normalizer. Takes an unpacked result (sign, signed unbiased exponent, normalized mantissa with three extra low bits, class flags) from the sqrt core and produces an IEEE-754 binary16 word. It handles:
- round-to-nearest-even;
- denormalization into the subnormal range;
- overflow to infinity;
- special-value encoding.

It is a two-stage pipeline, one result per cycle, with no backpressure.

## Interface
- No parameters.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  synchronous clear; when low, both stages are cleared on the next edge.
- r_valid  in  1  input word valid.
- sign_in  in  1  result sign.
- exp_in  in  7  signed unbiased exponent, range -64..63.
- mant_in  in  14  [13] integer bit, [12:3] fraction, [2:0] extra precision bits. Must be normalized ([13]=1) or all-zero.
- is_num_in, is_nan_in, is_pinf_in, is_ninf_in  in  1 each  class flags.
- p_valid  out  1  result valid.
- result  out  16  packed binary16.
- inexact, overflow, underflow  out  1 each  exception flags, aligned with result.

## Operation
- Class priority: nan > pinf > ninf > num.
  - nan → 16'h7E00, sign forced to 0.
  - pinf → 16'h7C00.
  - ninf → 16'hFC00.
- Zero cases → {sign_in, 15'b0}, all flags 0:
  - is_num with mant_in == 0;
  - no class flag set.
- Stage 1 (align):
  - Compute biased = exp_in + 15, signed 8-bit.
  - biased ≥ 31 → overflow: result {sign, 16'h7C00[14:0]}, overflow = 1, inexact = 1.
  - 1 ≤ biased ≤ 30 → normal:
    - efield = biased[4:0]
    - frac = mant_in[12:3]
    - g = mant_in[2]
    - s = |mant_in[1:0]
  - biased ≤ 0 → subnormal:
    - sh = 1 − biased, saturated at 15.
    - kept = mant_in >> sh.
    - efield = 0, frac = kept[12:3], g = kept[2].
    - s = |kept[1:0] OR the OR of all bits shifted out.
  - Register: sign, class, efield, frac, g, s, tiny (= subnormal path).
- Stage 2 (round/pack):
  - rnd = g & (s | frac[0]).
  - mag = {efield, frac} + rnd, 15-bit add.
    - The carry propagates naturally: a subnormal rounding up to 0x0400 becomes the minimum normal; 0x7BFF + 1 becomes 0x7C00 (infinity).
  - result = {sign, mag}.
  - inexact = g | s.
  - overflow = 1 if mag == 15'h7C00 from a num.
  - underflow = tiny & inexact.
- Special and zero classes bypass rounding; flags are 0 except for the stage-1 overflow case.

## Timing
- Latency 2: a word sampled with r_valid = 1 at edge N appears with p_valid = 1 after edge N+2.
- Throughput: one word per cycle, back-to-back, with independent per-stage valid bits.
- A cycle with r_valid = 0 creates a bubble: p_valid = 0 two cycles later. result and flags hold their last values.
- rst_n low (asynchronous, any time): both stages clear immediately. p_valid, result, inexact, overflow and underflow are all 0 and stay 0 until rst_n deasserts.
- enable low at an edge: both stage valids and all outputs clear to 0 at that edge. Words in flight are dropped, not replayed.
- Words accepted on the first edge after enable returns high emerge normally 2 cycles later.
- Input flags and data are only sampled when r_valid = 1.

## Test plan
- Normal and RNE:
  - exp_in 0, mant_in 0x2000 → 0x3C00, flags 0.
  - mant_in 0x2004 (tie, even) → 0x3C00, inexact = 1.
  - mant_in 0x200C (tie, odd) → 0x3C02, inexact = 1.
- Carry overflow: exp_in 15, mant_in 0x3FFC → 0x7C00, overflow = 1, inexact = 1.
- Direct overflow: exp_in 16, sign 1 → 0xFC00, overflow = 1.
- Subnormal:
  - exp_in −15, mant 0x2000 → 0x0200.
  - exp_in −24 → 0x0001, flags 0.
  - exp_in −25 → 0x0000, inexact = 1, underflow = 1.
  - exp_in −64, mant 0x3FFF → 0x0000, inexact = 1.
- Specials and zero:
  - nan with pinf also set → 0x7E00.
  - ninf → 0xFC00.
  - is_num, sign 1, mant 0 → 0x8000.
  - no flags → signed zero.
- Pipeline control:
  - 5 back-to-back words → 5 consecutive p_valid pulses starting 2 cycles later, in order.
  - enable low for 1 cycle mid-stream → the two in-flight words are dropped and outputs read 0.
  - rst_n pulse between edges → outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fp16_pack.sv
// fp16_pack: packs an unpacked sqrt-core result into IEEE-754 binary16.
// Round-to-nearest-even, subnormal denormalization, overflow and special encoding.
module fp16_pack (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        r_valid,
    input  logic        sign_in,
    input  logic [6:0]  exp_in,
    input  logic [13:0] mant_in,
    input  logic        is_num_in,
    input  logic        is_nan_in,
    input  logic        is_pinf_in,
    input  logic        is_ninf_in,
    output logic        p_valid,
    output logic [15:0] result,
    output logic        inexact,
    output logic        overflow,
    output logic        underflow
);

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_NUM,
        CLS_OVF,
        CLS_NAN,
        CLS_PINF,
        CLS_NINF
    } cls_t;

    // Input capture register: gives the N+2 sample-to-output latency.
    logic        s0_valid;
    logic        s0_sign;
    logic [6:0]  s0_exp;
    logic [13:0] s0_mant;
    logic        s0_num;
    logic        s0_nan;
    logic        s0_pinf;
    logic        s0_ninf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid <= 1'b0;
            s0_sign  <= 1'b0;
            s0_exp   <= '0;
            s0_mant  <= '0;
            s0_num   <= 1'b0;
            s0_nan   <= 1'b0;
            s0_pinf  <= 1'b0;
            s0_ninf  <= 1'b0;
        end else if (!enable) begin
            s0_valid <= 1'b0;
        end else begin
            s0_valid <= r_valid;
            if (r_valid) begin
                s0_sign <= sign_in;
                s0_exp  <= exp_in;
                s0_mant <= mant_in;
                s0_num  <= is_num_in;
                s0_nan  <= is_nan_in;
                s0_pinf <= is_pinf_in;
                s0_ninf <= is_ninf_in;
            end
        end
    end

    // Stage 1: alignment
    logic signed [7:0] biased;
    logic signed [7:0] sh_full;
    logic [3:0]        sh;
    logic [13:0]       kept;
    logic [13:0]       lost_mask;
    cls_t              a_cls;
    logic [4:0]        a_efield;
    logic [9:0]        a_frac;
    logic              a_g;
    logic              a_s;
    logic              a_tiny;

    always_comb begin
        a_cls     = CLS_ZERO;
        a_efield  = '0;
        a_frac    = '0;
        a_g       = 1'b0;
        a_s       = 1'b0;
        a_tiny    = 1'b0;
        biased    = {s0_exp[6], s0_exp} + 8'sd15;
        sh_full   = 8'sd1 - biased;
        sh        = (sh_full > 8'sd15) ? 4'd15 : sh_full[3:0];
        kept      = s0_mant >> sh;
        lost_mask = ~(14'h3FFF << sh);
        if (s0_nan) begin
            a_cls = CLS_NAN;
        end else if (s0_pinf) begin
            a_cls = CLS_PINF;
        end else if (s0_ninf) begin
            a_cls = CLS_NINF;
        end else if (s0_num && (s0_mant != '0)) begin
            if (biased >= 8'sd31) begin
                a_cls = CLS_OVF;
            end else if (biased >= 8'sd1) begin
                a_cls    = CLS_NUM;
                a_efield = biased[4:0];
                a_frac   = s0_mant[12:3];
                a_g      = s0_mant[2];
                a_s      = |s0_mant[1:0];
            end else begin
                // Shifted-out bits fold into sticky so rounding stays exact.
                a_cls  = CLS_NUM;
                a_tiny = 1'b1;
                a_frac = kept[12:3];
                a_g    = kept[2];
                a_s    = (|kept[1:0]) | (|(s0_mant & lost_mask));
            end
        end
    end

    logic       s1_valid;
    logic       s1_sign;
    cls_t       s1_cls;
    logic [4:0] s1_efield;
    logic [9:0] s1_frac;
    logic       s1_g;
    logic       s1_s;
    logic       s1_tiny;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_cls    <= CLS_ZERO;
            s1_efield <= '0;
            s1_frac   <= '0;
            s1_g      <= 1'b0;
            s1_s      <= 1'b0;
            s1_tiny   <= 1'b0;
        end else if (!enable) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= s0_valid;
            if (s0_valid) begin
                s1_sign   <= s0_sign;
                s1_cls    <= a_cls;
                s1_efield <= a_efield;
                s1_frac   <= a_frac;
                s1_g      <= a_g;
                s1_s      <= a_s;
                s1_tiny   <= a_tiny;
            end
        end
    end

    // Stage 2: round and pack; the exponent carry handles renormalization
    logic        rnd;
    logic [14:0] mag;
    logic [15:0] r_word;
    logic        r_ix;
    logic        r_ov;
    logic        r_uf;

    assign rnd = s1_g & (s1_s | s1_frac[0]);
    assign mag = {s1_efield, s1_frac} + {14'd0, rnd};

    always_comb begin
        r_word = {s1_sign, 15'd0};
        r_ix   = 1'b0;
        r_ov   = 1'b0;
        r_uf   = 1'b0;
        unique case (s1_cls)
            CLS_NUM: begin
                r_word = {s1_sign, mag};
                r_ix   = s1_g | s1_s;
                r_ov   = (mag == 15'h7C00);
                r_uf   = s1_tiny & (s1_g | s1_s);
            end
            CLS_OVF: begin
                r_word = {s1_sign, 15'h7C00};
                r_ix   = 1'b1;
                r_ov   = 1'b1;
            end
            CLS_NAN:  r_word = 16'h7E00;
            CLS_PINF: r_word = 16'h7C00;
            CLS_NINF: r_word = 16'hFC00;
            default:  r_word = {s1_sign, 15'd0};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid   <= 1'b0;
            result    <= '0;
            inexact   <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (!enable) begin
            p_valid   <= 1'b0;
            result    <= '0;
            inexact   <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            p_valid <= s1_valid;
            if (s1_valid) begin
                result    <= r_word;
                inexact   <= r_ix;
                overflow  <= r_ov;
                underflow <= r_uf;
            end
        end
    end

endmodule

// File: tb/tb_fp16_pack.sv
// Testbench for fp16_pack: directed spec cases plus random stimulus
// checked against an exact-arithmetic rounding model and a latency model.
module tb_fp16_pack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        r_valid;
    logic        sign_in;
    logic [6:0]  exp_in;
    logic [13:0] mant_in;
    logic        is_num_in, is_nan_in, is_pinf_in, is_ninf_in;
    logic        p_valid;
    logic [15:0] result;
    logic        inexact, overflow, underflow;

    int checks = 0;
    int errors = 0;

    // model state: two in-flight words and the visible output {p_valid,result,ix,ov,uf}
    bit          pipe0_v, pipe1_v;
    logic [18:0] pipe0_w, pipe1_w;
    logic [19:0] model_out;

    always #5 clk = ~clk;

    fp16_pack dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .r_valid   (r_valid),
        .sign_in   (sign_in),
        .exp_in    (exp_in),
        .mant_in   (mant_in),
        .is_num_in (is_num_in),
        .is_nan_in (is_nan_in),
        .is_pinf_in(is_pinf_in),
        .is_ninf_in(is_ninf_in),
        .p_valid   (p_valid),
        .result    (result),
        .inexact   (inexact),
        .overflow  (overflow),
        .underflow (underflow)
    );

    function automatic logic [19:0] dut_vec();
        return {p_valid, result, inexact, overflow, underflow};
    endfunction

    // Exact value is m * 2^(e-13); round to a multiple of the fp16 quantum.
    function automatic logic [18:0] ref_word(input bit sg, input int e,
                                             input logic [13:0] m, input logic [3:0] cls);
        longint unsigned mm, n, r, half;
        int d, mag;
        bit ix, up;
        if (cls[3]) return {16'h7E00, 3'b000};
        if (cls[2]) return {16'h7C00, 3'b000};
        if (cls[1]) return {16'hFC00, 3'b000};
        if (!cls[0] || m == 14'd0) return {sg, 15'd0, 3'b000};
        if (e >= 16) return {sg, 15'h7C00, 3'b110};
        d    = (e < -14) ? 3 + (-14 - e) : 3;
        mm   = 64'(m);
        n    = mm >> d;
        r    = mm & ((64'd1 << d) - 64'd1);
        half = 64'd1 << (d - 1);
        up   = (r > half) || ((r == half) && n[0]);
        n    = n + 64'(up);
        mag  = ((e >= -14) ? (e + 14) * 1024 : 0) + int'(n);
        ix   = (r != 0);
        return {sg, mag[14:0], ix, (mag >= 32'h7C00), ((e < -14) && ix)};
    endfunction

    task automatic model_reset();
        pipe0_v   = 1'b0;
        pipe1_v   = 1'b0;
        pipe0_w   = '0;
        pipe1_w   = '0;
        model_out = '0;
    endtask

    // Drive one cycle from a negedge, advance the model at the posedge, return at the next negedge.
    task automatic cycle(input bit v, input bit sg, input int e, input logic [13:0] m,
                         input logic [3:0] cls, input bit en);
        r_valid = v;
        sign_in = sg;
        exp_in  = e[6:0];
        mant_in = m;
        {is_nan_in, is_pinf_in, is_ninf_in, is_num_in} = cls;
        enable  = en;
        @(posedge clk);
        if (!en) begin
            model_reset();
        end else begin
            model_out[19] = pipe1_v;
            if (pipe1_v) model_out[18:0] = pipe1_w;
            pipe1_v = pipe0_v;
            pipe1_w = pipe0_w;
            pipe0_v = v;
            if (v) pipe0_w = ref_word(sg, e, m, cls);
        end
        @(negedge clk);
    endtask

    task automatic gen(output bit sg, output int e, output logic [13:0] m, output logic [3:0] cls);
        int k;
        sg = 1'($urandom);
        e  = ($urandom % 2 == 0) ? $urandom_range(0, 127) - 64 : $urandom_range(0, 50) - 30;
        m  = 14'h2000 | 14'($urandom_range(0, 8191));
        k  = $urandom_range(0, 15);
        case (k)
            0:       cls = 4'b1000 | 4'($urandom_range(0, 7));
            1:       cls = 4'b0100 | 4'($urandom_range(0, 3));
            2:       cls = 4'b0010 | 4'($urandom_range(0, 1));
            3:       cls = 4'b0000;
            4: begin cls = 4'b0001; m = 14'd0; end
            default: cls = 4'b0001;
        endcase
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b1;
        cycle(1'b0, 1'b0, 0, 14'd0, 4'd0, 1'b1);
        cycle(1'b0, 1'b0, 0, 14'd0, 4'd0, 1'b1);
        checks++;
        if (dut_vec() !== 20'h0) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", dut_vec(), 20'h0);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit          sg;
        int          e;
        logic [13:0] m;
        logic [3:0]  cls;
        logic [18:0] want;
    } dir_t;

    task automatic test_directed();
        dir_t tbl[13];
        tbl[0]  = '{0,   0, 14'h2000, 4'b0001, {16'h3C00, 3'b000}};
        tbl[1]  = '{0,   0, 14'h2004, 4'b0001, {16'h3C00, 3'b100}};
        tbl[2]  = '{0,   0, 14'h200C, 4'b0001, {16'h3C02, 3'b100}};
        tbl[3]  = '{0,  15, 14'h3FFC, 4'b0001, {16'h7C00, 3'b110}};
        tbl[4]  = '{1,  16, 14'h2000, 4'b0001, {16'hFC00, 3'b110}};
        tbl[5]  = '{0, -15, 14'h2000, 4'b0001, {16'h0200, 3'b000}};
        tbl[6]  = '{0, -24, 14'h2000, 4'b0001, {16'h0001, 3'b000}};
        tbl[7]  = '{0, -25, 14'h2000, 4'b0001, {16'h0000, 3'b101}};
        tbl[8]  = '{0, -64, 14'h3FFF, 4'b0001, {16'h0000, 3'b101}};
        tbl[9]  = '{1,   3, 14'h2000, 4'b1100, {16'h7E00, 3'b000}};
        tbl[10] = '{0,   3, 14'h2000, 4'b0010, {16'hFC00, 3'b000}};
        tbl[11] = '{1,   5, 14'h0000, 4'b0001, {16'h8000, 3'b000}};
        tbl[12] = '{1,   5, 14'h2000, 4'b0000, {16'h8000, 3'b000}};
        foreach (tbl[i]) begin
            cycle(1'b1, tbl[i].sg, tbl[i].e, tbl[i].m, tbl[i].cls, 1'b1);
            cycle(1'b0, 1'b0, 0, 14'd0, 4'd0, 1'b1);
            cycle(1'b0, 1'b0, 0, 14'd0, 4'd0, 1'b1);
            checks++;
            if (dut_vec() !== {1'b1, tbl[i].want}) begin
                errors++;
                $display("FAIL directed[%0d]: got %h expected %h", i, dut_vec(), {1'b1, tbl[i].want});
            end
        end
    endtask

    task automatic test_random();
        bit sg;
        int e;
        logic [13:0] m;
        logic [3:0] cls;
        for (int i = 0; i < 600; i++) begin
            gen(sg, e, m, cls);
            cycle(($urandom % 4) != 0, sg, e, m, cls, ($urandom % 60) != 0);
            checks++;
            if (dut_vec() !== model_out) begin
                errors++;
                $display("FAIL random[%0d]: got %h expected %h", i, dut_vec(), model_out);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit sg;
        int e;
        logic [13:0] m;
        logic [3:0] cls;
        int pulses = 0;
        for (int i = 0; i < 9; i++) begin
            gen(sg, e, m, cls);
            cycle(i < 5, sg, e, m, cls, 1'b1);
            if (p_valid === 1'b1) pulses++;
            checks++;
            if (dut_vec() !== model_out || p_valid !== (i >= 2 && i <= 6)) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got %h expected %h", i, dut_vec(), model_out);
            end
        end
        checks++;
        if (pulses != 5) begin
            errors++;
            $display("FAIL back_to_back_pulses: got %0d expected 5", pulses);
        end
    endtask

    task automatic test_enable();
        int pulses = 0;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, i, 14'h2000, 4'b0001, 1'b1);
        cycle(1'b1, 1'b0, 7, 14'h2000, 4'b0001, 1'b0);
        checks++;
        if (dut_vec() !== 20'h0) begin
            errors++;
            $display("FAIL enable_clear: got %h expected %h", dut_vec(), 20'h0);
        end
        cycle(1'b1, 1'b1, 1, 14'h2000, 4'b0001, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 0, 14'd0, 4'd0, 1'b1);
            if (p_valid === 1'b1) pulses++;
            checks++;
            if (dut_vec() !== model_out) begin
                errors++;
                $display("FAIL enable_resume[%0d]: got %h expected %h", i, dut_vec(), model_out);
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL enable_drop: got %0d pulses expected 1", pulses);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 0, 14'h2000, 4'b0001, 1'b1);
        checks++;
        if (dut_vec() !== model_out) begin
            errors++;
            $display("FAIL async_pre: got %h expected %h", dut_vec(), model_out);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec() !== 20'h0) begin
            errors++;
            $display("FAIL async_reset_immediate: got %h expected %h", dut_vec(), 20'h0);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (dut_vec() !== 20'h0) begin
            errors++;
            $display("FAIL async_reset_hold: got %h expected %h", dut_vec(), 20'h0);
        end
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(i == 0, 1'b0, 0, 14'h2004, 4'b0001, 1'b1);
            checks++;
            if (dut_vec() !== model_out) begin
                errors++;
                $display("FAIL async_recover[%0d]: got %h expected %h", i, dut_vec(), model_out);
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        enable  = 1'b1;
        r_valid = 1'b0;
        sign_in = 1'b0;
        exp_in  = '0;
        mant_in = '0;
        {is_nan_in, is_pinf_in, is_ninf_in, is_num_in} = 4'b0;
        model_reset();
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_enable();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
